// File: rtl/lp_pipe_pkg.sv
// Shared types, constants and helpers for the lp_pipe launch/sink controller.
package lp_pipe_pkg;

  // Default widths of the lp_piped_* family.
  localparam int unsigned LpSumWidth = 17;
  localparam int unsigned LpIdWidth  = 8;
  localparam int unsigned LpDepth    = 4;

  // Number of distinct IDs at the default width (IDs wrap modulo this).
  localparam int unsigned ID_WRAP = 2 ** LpIdWidth;

  // Buffered result at the default widths.
  typedef struct packed {
    logic [LpIdWidth-1:0]  id;
    logic [LpSumWidth-1:0] sum;
  } lp_result_t;

  // ceil(log2(n+1)): bits needed to hold the values 0..n.
  function automatic int unsigned clog2p1(input int unsigned n);
    int unsigned w;
    w = 0;
    while ((64'd1 << w) <= 64'(n)) w++;
    return w;
  endfunction

endpackage

// File: rtl/lp_pipe_launch_sink_if.sv
// Handshake bundle between the launch/sink controller, upstream, the pipe and downstream.
interface lp_pipe_launch_sink_if #(
  parameter int unsigned SumWidth = 17,
  parameter int unsigned IdWidth  = 8,
  parameter int unsigned CntWidth = 3
);
  logic                in_valid;
  logic                in_ready;
  logic                launch;
  logic [IdWidth-1:0]  launch_id;
  logic                arrive;
  logic [IdWidth-1:0]  arrive_id;
  logic [SumWidth-1:0] sum;
  logic                accept_n;
  logic                out_valid;
  logic                out_ready;
  logic [SumWidth-1:0] out_sum;
  logic [IdWidth-1:0]  out_id;
  logic [CntWidth-1:0] outstanding;
  logic                idle;
  logic                id_err;

  // Controller side.
  modport master (
    input  in_valid, arrive, arrive_id, sum, out_ready,
    output in_ready, launch, launch_id, accept_n, out_valid, out_sum, out_id,
           outstanding, idle, id_err
  );

  // Environment side (upstream, pipe and downstream).
  modport slave (
    output in_valid, arrive, arrive_id, sum, out_ready,
    input  in_ready, launch, launch_id, accept_n, out_valid, out_sum, out_id,
           outstanding, idle, id_err
  );
endinterface

// File: rtl/lp_pipe_result_fifo.sv
// Small synchronous FIFO holding returned {id, sum} results.
module lp_pipe_result_fifo
  import lp_pipe_pkg::*;
#(
  parameter int unsigned Width    = LpIdWidth + LpSumWidth,
  parameter int unsigned Depth    = LpDepth,
  parameter int unsigned CntWidth = clog2p1(Depth)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_push,
  input  logic [Width-1:0]    i_data,
  input  logic                i_pop,
  output logic                o_full,
  output logic                o_empty,
  output logic [CntWidth-1:0] o_count,
  output logic [Width-1:0]    o_head
);
  localparam int unsigned PtrWidth = (Depth > 1) ? $clog2(Depth) : 1;

  logic [Width-1:0]    r_mem [Depth];
  logic [PtrWidth-1:0] r_wr_ptr;
  logic [PtrWidth-1:0] r_rd_ptr;
  logic [CntWidth-1:0] r_count;
  logic                w_push;
  logic                w_pop;

  // Pointers wrap at Depth, which need not be a power of two.
  function automatic logic [PtrWidth-1:0] ptr_inc(input logic [PtrWidth-1:0] p);
    return (p == PtrWidth'(Depth - 1)) ? '0 : p + PtrWidth'(1);
  endfunction

  assign o_full  = (r_count == CntWidth'(Depth));
  assign o_empty = (r_count == '0);
  assign w_push  = i_push & ~o_full;
  assign w_pop   = i_pop & ~o_empty;
  assign o_count = r_count;
  assign o_head  = r_mem[r_rd_ptr];

  // Storage is cleared on reset so the head reads zero after reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < Depth; i++) r_mem[i] <= '0;
    end else if (w_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  // Pointer and occupancy update.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (w_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CntWidth'(1);
        2'b01:   r_count <= r_count - CntWidth'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/lp_pipe_launch_sink.sv
// Launch/sink controller: issues sequential launch IDs under a credit limit,
// buffers pipe results, checks arrival order and presents results downstream.
module lp_pipe_launch_sink
  import lp_pipe_pkg::*;
#(
  parameter int unsigned SumWidth = LpSumWidth,
  parameter int unsigned IdWidth  = LpIdWidth,
  parameter int unsigned Depth    = LpDepth,
  parameter int unsigned CntWidth = clog2p1(Depth)
) (
  input logic                  clk,
  input logic                  rst_n,
  lp_pipe_launch_sink_if.master bus
);
  typedef struct packed {
    logic [IdWidth-1:0]  id;
    logic [SumWidth-1:0] sum;
  } res_t;

  localparam logic [CntWidth-1:0] DepthCnt = CntWidth'(Depth);

  logic [IdWidth-1:0]  r_next_id;
  logic [IdWidth-1:0]  r_exp_id;
  logic [CntWidth-1:0] r_outstanding;
  logic                r_id_err;

  logic                w_in_ready;
  logic                w_launch;
  logic                w_take;
  logic                w_pop;
  logic                w_full;
  logic                w_empty;
  logic [CntWidth-1:0] w_fifo_count;
  logic                w_id_bad;
  res_t                w_push_data;
  res_t                w_head;

  // Credits come from registered state only, so in_ready has no input path.
  assign w_in_ready  = (r_outstanding < DepthCnt);
  assign w_launch    = bus.in_valid & w_in_ready;
  assign w_take      = bus.arrive & ~w_full;
  assign w_pop       = ~w_empty & bus.out_ready;
  assign w_push_data = '{id: bus.arrive_id, sum: bus.sum};
  // Out of order, or nothing in flight (every outstanding op already buffered).
  assign w_id_bad    = (bus.arrive_id != r_exp_id) || (r_outstanding == w_fifo_count);

  lp_pipe_result_fifo #(
    .Width    ($bits(res_t)),
    .Depth    (Depth),
    .CntWidth (CntWidth)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_take),
    .i_data  (w_push_data),
    .i_pop   (w_pop),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_fifo_count),
    .o_head  (w_head)
  );

  // ID generator, ID checker and credit counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_next_id     <= '0;
      r_exp_id      <= '0;
      r_outstanding <= '0;
      r_id_err      <= 1'b0;
    end else begin
      if (w_launch) r_next_id <= r_next_id + IdWidth'(1);
      if (w_take) begin
        r_exp_id <= r_exp_id + IdWidth'(1);
        if (w_id_bad) r_id_err <= 1'b1;
      end
      case ({w_launch, w_pop})
        2'b10:   r_outstanding <= r_outstanding + CntWidth'(1);
        // Guard keeps a stale post-reset result from underflowing the count.
        2'b01:   if (r_outstanding != '0) r_outstanding <= r_outstanding - CntWidth'(1);
        default: r_outstanding <= r_outstanding;
      endcase
    end
  end

  assign bus.in_ready    = w_in_ready;
  assign bus.launch      = w_launch;
  assign bus.launch_id   = r_next_id;
  assign bus.accept_n    = w_full;
  assign bus.out_valid   = ~w_empty;
  assign bus.out_sum     = w_head.sum;
  assign bus.out_id      = w_head.id;
  assign bus.outstanding = r_outstanding;
  assign bus.idle        = (r_outstanding == '0);
  assign bus.id_err      = r_id_err;

endmodule
